// File: rtl/stk_seq_ctrl.sv
// stk_seq_ctrl: fetch/decode/issue sequencer for the stack-machine datapath.
// Fetches instruction words, issues unit opcodes on control_bus with a
// one-cycle unit_en strobe, and handles jumps, halt and stack-bound errors.
// The optional WAIT timeout is enabled by defining STK_SEQ_TIMEOUT_EN.
module stk_seq_ctrl #(
  parameter int DATA_LEN       = 8,
  parameter int PC_LEN         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PC_LEN-1:0]     imem_addr,
  output logic                  imem_rd,
  input  logic [DATA_LEN+3:0]   imem_data,
  input  logic                  stk_empty,
  input  logic                  stk_full,
  input  logic [DATA_LEN-1:0]   stk_top,
  output logic [3:0]            control_bus,
  output logic                  unit_en,
  output logic [DATA_LEN-1:0]   addr_const,
  input  logic                  unit_done,
  output logic [PC_LEN-1:0]     pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [3:0] OP_PUSHC = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_JZ    = 4'd6;
  localparam logic [3:0] OP_NOP   = 4'd7;

  localparam logic [1:0] E_ILLEGAL   = 2'd0;
  localparam logic [1:0] E_UNDERFLOW = 2'd1;
  localparam logic [1:0] E_OVERFLOW  = 2'd2;
`ifdef STK_SEQ_TIMEOUT_EN
  localparam logic [1:0] E_TIMEOUT   = 2'd3;
  localparam int         CW          = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]         wait_cnt;
`endif

  logic [2:0]          state;
  logic [3:0]          opcode;
  logic [DATA_LEN-1:0] operand;
  logic [PC_LEN-1:0]   jmp_tgt;

  assign opcode  = imem_data[DATA_LEN+3:DATA_LEN];
  assign operand = imem_data[DATA_LEN-1:0];
  assign jmp_tgt = PC_LEN'(operand);

  // Status and strobes are pure functions of state; imem_addr tracks pc.
  assign imem_addr = pc;
  assign imem_rd   = (state == S_FETCH);
  assign unit_en   = (state == S_ISSUE);
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_ISSUE) || (state == S_WAIT);
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERR);

  // Sequencer: state, program counter, issued opcode/operand and error code.
  // control_bus/addr_const double as the instruction register for issued ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      control_bus <= '0;
      addr_const  <= '0;
      err_code    <= '0;
`ifdef STK_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          pc <= pc + PC_LEN'(1);
          if (opcode inside {[4'd8:4'd14]}) begin
            err_code <= E_ILLEGAL;
            state    <= S_ERR;
          end else if ((opcode inside {OP_STORE, OP_ADD, OP_SUB, OP_JZ}) && stk_empty) begin
            err_code <= E_UNDERFLOW;
            state    <= S_ERR;
          end else if ((opcode inside {OP_PUSHC, OP_LOAD}) && stk_full) begin
            err_code <= E_OVERFLOW;
            state    <= S_ERR;
          end else if (opcode <= OP_SUB) begin
            control_bus <= opcode;
            addr_const  <= operand;
            state       <= S_ISSUE;
          end else begin
            case (opcode)
              OP_JMP: begin
                pc    <= jmp_tgt;
                state <= S_FETCH;
              end
              OP_JZ: begin
                if (stk_top == '0) pc <= jmp_tgt;
                state <= S_FETCH;
              end
              OP_NOP:  state <= S_FETCH;
              default: state <= S_HALT;
            endcase
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef STK_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (unit_done) begin
            state <= S_FETCH;
`ifdef STK_SEQ_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            err_code <= E_TIMEOUT;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        S_HALT, S_ERR: begin
          if (start) begin
            err_code <= '0;
            pc       <= '0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stk_seq_ctrl.sv
// tb_stk_seq_ctrl: self-checking bench for stk_seq_ctrl with a synchronous
// instruction memory model, a unit responder and an issue scoreboard.
module tb_stk_seq_ctrl;
  localparam int DL = 8;
  localparam int PL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PL-1:0] imem_addr;
  logic          imem_rd;
  logic [DL+3:0] imem_data;
  logic          stk_empty = 1'b0;
  logic          stk_full = 1'b0;
  logic [DL-1:0] stk_top = '0;
  logic [3:0]    control_bus;
  logic          unit_en;
  logic [DL-1:0] addr_const;
  logic          unit_done;
  logic [PL-1:0] pc;
  logic          busy, halted, err;
  logic [1:0]    err_code;

  int errors = 0;
  int checks = 0;
  int en_count = 0;

  stk_seq_ctrl #(.DATA_LEN(DL), .PC_LEN(PL), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_top(stk_top),
    .control_bus(control_bus), .unit_en(unit_en), .addr_const(addr_const),
    .unit_done(unit_done), .pc(pc), .busy(busy), .halted(halted),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, data valid the cycle after imem_rd.
  logic [DL+3:0] mem [0:255];
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  // Unit responder: optional automatic done one cycle after unit_en.
  logic auto_done = 1'b0;
  logic model_done = 1'b0;
  logic force_done = 1'b0;
  always @(posedge clk) model_done <= unit_en & auto_done;
  assign unit_done = model_done | force_done;

  typedef struct {
    logic [3:0]    op;
    logic [DL-1:0] arg;
    bit            care;
  } exp_t;
  exp_t sb[$];

  // Issue monitor: every unit_en pops one expected (opcode, operand).
  always @(negedge clk) begin
    if (unit_en === 1'b1) begin
      exp_t e;
      en_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got control_bus=%0d addr_const=%0h, none expected",
                 control_bus, addr_const);
      end else begin
        e = sb.pop_front();
        if (control_bus !== e.op || (e.care && addr_const !== e.arg)) begin
          errors++;
          $display("FAIL issue: got (%0d,%0h) expected (%0d,%0h)",
                   control_bus, addr_const, e.op, e.arg);
        end
      end
    end
  end

  function automatic logic [DL+3:0] ins(input logic [3:0] op, input logic [DL-1:0] arg);
    return {op, arg};
  endfunction

  task automatic expect_issue(input logic [3:0] op, input logic [DL-1:0] arg, input bit care);
    exp_t e;
    e.op = op; e.arg = arg; e.care = care;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ins(4'd15, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; force_done = 1'b0;
    stk_empty = 1'b0; stk_full = 1'b0; stk_top = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_stop(output int cyc);
    cyc = 0;
    while (!(halted === 1'b1 || err === 1'b1) && cyc < 300) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic wait_issue(output bit ok);
    int n = 0;
    while (unit_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (unit_en === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pc, imem_rd, imem_addr, control_bus, unit_en, addr_const} !== '0) begin
      errors++;
      $display("FAIL reset_datapath: pc=%0h rd=%0b addr=%0h cb=%0d en=%0b ac=%0h required all 0",
               pc, imem_rd, imem_addr, control_bus, unit_en, addr_const);
    end
    checks++;
    if ({busy, halted, err, err_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%0b halted=%0b err=%0b code=%0d required 0",
               busy, halted, err, err_code);
    end
    start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: busy=%0b imem_rd=%0b required 0", busy, imem_rd);
    end
  endtask

  task automatic test_program();
    int cyc = 0;
    int en0;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd0, 8'h05);
    mem[1] = ins(4'd0, 8'h07);
    mem[2] = ins(4'd3, 8'hAA);
    mem[3] = ins(4'd2, 8'h20);
    mem[4] = ins(4'd15, 8'h00);
    auto_done = 1'b1; stk_top = 8'd1;
    expect_issue(4'd0, 8'h05, 1'b1);
    expect_issue(4'd0, 8'h07, 1'b1);
    expect_issue(4'd3, 8'h00, 1'b0);
    expect_issue(4'd2, 8'h20, 1'b1);
    en0 = en_count;
    @(negedge clk); start = 1'b1;
    while (halted !== 1'b1 && cyc < 200) begin
      @(negedge clk); start = 1'b0; cyc++;
    end
    checks++;
    if (halted !== 1'b1 || pc !== 8'd5) begin
      errors++;
      $display("FAIL prog_halt: halted=%0b pc=%0d required 1 and 5", halted, pc);
    end
    // cyc counts cycles after the start cycle; +1 includes the start cycle
    checks++;
    if (cyc + 1 != 2 + 4 * 4 + 2) begin
      errors++;
      $display("FAIL prog_latency: got %0d cycles required %0d", cyc + 1, 2 + 4 * 4 + 2);
    end
    checks++;
    if (en_count - en0 != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL prog_issue_count: got %0d issues, %0d pending, required 4 and 0",
               en_count - en0, sb.size());
    end
  endtask

  task automatic run_fetches(output logic [PL-1:0] a2, output int gap);
    int cyc = 0, n = 0, c0 = 0, c1 = 0;
    a2 = '0;
    @(negedge clk); start = 1'b1;
    while (n < 3 && cyc < 50) begin
      @(negedge clk); start = 1'b0; cyc++;
      if (imem_rd === 1'b1) begin
        if (n == 0) c0 = cyc;
        if (n == 1) c1 = cyc;
        if (n == 2) a2 = imem_addr;
        n++;
      end
    end
    gap = c1 - c0;
    wait_stop(cyc);
  endtask

  task automatic test_jump();
    logic [PL-1:0] a2;
    int gap;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd5, 8'h03);
    mem[3] = ins(4'd6, 8'h10);
    stk_top = 8'd0;
    run_fetches(a2, gap);
    checks++;
    if (a2 !== 8'h10) begin
      errors++;
      $display("FAIL jz_taken: imem_addr=%0h required 10", a2);
    end
    checks++;
    if (gap != 2) begin
      errors++;
      $display("FAIL jmp_latency: got %0d cycles required 2", gap);
    end
    checks++;
    if (halted !== 1'b1 || pc !== 8'h11) begin
      errors++;
      $display("FAIL jz_taken_halt: halted=%0b pc=%0h required 1 and 11", halted, pc);
    end
    stk_top = 8'd9;
    run_fetches(a2, gap);
    checks++;
    if (a2 !== 8'h04) begin
      errors++;
      $display("FAIL jz_not_taken: imem_addr=%0h required 4", a2);
    end
    checks++;
    if (halted !== 1'b1 || pc !== 8'h05) begin
      errors++;
      $display("FAIL jz_not_taken_halt: halted=%0b pc=%0h required 1 and 5", halted, pc);
    end
  endtask

  task automatic test_illegal();
    int cyc, en0;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd7, 8'h00);
    mem[1] = ins(4'd7, 8'h00);
    mem[2] = ins(4'd9, 8'h00);
    en0 = en_count;
    kick();
    wait_stop(cyc);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd0 || pc !== 8'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op: err=%0b code=%0d pc=%0d busy=%0b required 1,0,3,0",
               err, err_code, pc, busy);
    end
    checks++;
    if (en_count != en0) begin
      errors++;
      $display("FAIL illegal_no_issue: got %0d issues required 0", en_count - en0);
    end
    kick();
    checks++;
    if (err !== 1'b0 || imem_addr !== 8'd0 || imem_rd !== 1'b1) begin
      errors++;
      $display("FAIL err_restart: err=%0b imem_addr=%0h rd=%0b required 0,0,1",
               err, imem_addr, imem_rd);
    end
    do_reset();
  endtask

  task automatic test_stack_err();
    int cyc, en0;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd2, 8'h20);
    stk_empty = 1'b1;
    en0 = en_count;
    kick();
    wait_stop(cyc);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || en_count != en0) begin
      errors++;
      $display("FAIL underflow: err=%0b code=%0d issues=%0d required 1,1,0",
               err, err_code, en_count - en0);
    end
    mem[0] = ins(4'd0, 8'h01);
    stk_empty = 1'b0; stk_full = 1'b1;
    kick();
    wait_stop(cyc);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || en_count != en0) begin
      errors++;
      $display("FAIL overflow: err=%0b code=%0d issues=%0d required 1,2,0",
               err, err_code, en_count - en0);
    end
    stk_full = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int en0, rd_seen = 0;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd0, 8'h03);
    auto_done = 1'b0;
    expect_issue(4'd0, 8'h03, 1'b1);
    kick();
    wait_issue(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstwait_issue: unit_en=%0b required 1 within bound", unit_en);
    end
    @(negedge clk);
    en0 = en_count;
    rst = 1'b1; force_done = 1'b1;
    @(negedge clk);
    rst = 1'b0; force_done = 1'b0;
    checks++;
    if ({pc, imem_rd, imem_addr, control_bus, unit_en, addr_const, busy, halted, err, err_code} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: pc=%0h rd=%0b cb=%0d en=%0b ac=%0h busy=%0b err=%0b required all 0",
               pc, imem_rd, control_bus, unit_en, addr_const, busy, err);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_rd === 1'b1) rd_seen++;
    end
    checks++;
    if (rd_seen != 0 || busy !== 1'b0 || en_count != en0) begin
      errors++;
      $display("FAIL rstwait_idle: fetches=%0d busy=%0b issues=%0d required 0,0,0",
               rd_seen, busy, en_count - en0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = ins(4'd0, 8'h03);
    auto_done = 1'b0;
    expect_issue(4'd0, 8'h03, 1'b1);
    kick();
    wait_issue(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_issue: unit_en=%0b required 1 within bound", unit_en);
    end
`ifdef STK_SEQ_TIMEOUT_EN
    begin
      int w = 0;
      @(negedge clk);
      while (err !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      checks++;
      if (w != 16 || err_code !== 2'd3 || control_bus !== 4'd0 || addr_const !== 8'h03) begin
        errors++;
        $display("FAIL timeout_err: wait=%0d code=%0d cb=%0d ac=%0h required 16,3,0,03",
                 w, err_code, control_bus, addr_const);
      end
      do_reset();
      mem[1] = ins(4'd15, 8'h00);
      expect_issue(4'd0, 8'h03, 1'b1);
      kick();
      wait_issue(ok);
      repeat (16) @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early: err=%0b busy=%0b at wait 16 required 0,1", err, busy);
      end
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      checks++;
      if (err !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'd1) begin
        errors++;
        $display("FAIL timeout_done_wins: err=%0b rd=%0b addr=%0h required 0,1,1",
                 err, imem_rd, imem_addr);
      end
    end
`else
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: busy=%0b err=%0b after 100 cycles required 1,0", busy, err);
    end
`endif
    do_reset();
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program();
    test_jump();
    test_illegal();
    test_stack_err();
    test_reset_in_wait();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
